// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state codes, field widths and R/W encoding.
// Used by i2c_target and by the controller's bench.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_DATA_W = 8;

  // R/W bit that follows the address
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  // Target FSM state codes
  typedef logic [2:0] state_t;
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ADDR     = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK = 3'd2;
  localparam logic [2:0] ST_WR_DATA  = 3'd3;
  localparam logic [2:0] ST_WR_ACK   = 3'd4;
  localparam logic [2:0] ST_RD_DATA  = 3'd5;
  localparam logic [2:0] ST_RD_ACK   = 3'd6;
  localparam logic [2:0] ST_IGNORE   = 3'd7;

endpackage

// File: rtl/i2c_line_filter.sv
// Per-line input path: 2-flop synchronizer, optional deglitch filter
// (I2C_TARGET_FILTER_EN), registered sample and edge flags.
module i2c_line_filter #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic sample,
  output logic rise_c,
  output logic fall_c
);

  logic [1:0] sync;
  logic       clean;
  logic       prev;

  // Synchronizer; resets to the idle-high bus level
  always_ff @(posedge clk) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], line};
  end

`ifdef I2C_TARGET_FILTER_EN
  localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

  logic [CNT_W-1:0] cnt;
  logic             filt;

  // Accept a new level only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      filt <= 1'b1;
      cnt  <= '0;
    end else if (sync[1] == filt) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
      filt <= sync[1];
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign clean = filt;
`else
  // Filter length only matters when the filter is built in
  logic [31:0] unused_filter_len;
  assign unused_filter_len = 32'(FILTER_LEN);
  assign clean = sync[1];
`endif

  // Registered sample and its previous value for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sample <= 1'b1;
      prev   <= 1'b1;
    end else begin
      sample <= clean;
      prev   <= sample;
    end
  end

  assign rise_c = sample & ~prev;
  assign fall_c = ~sample & prev;

endmodule

// File: rtl/i2c_target.sv
// Single-clock I2C target: oversampled SCL/SDA, START/STOP detection,
// 7-bit address match, one-byte write or read per transaction.
// Optional input deglitch filter: define I2C_TARGET_FILTER_EN.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h29,
  parameter int unsigned           FILTER_LEN  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i2c_scl,
  inout  wire                   i2c_sda,
  input  logic [I2C_DATA_W-1:0] tx_data,
  output logic [I2C_DATA_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rd_req,
  output logic                  busy
);

  localparam int unsigned BIT_W = $clog2(I2C_DATA_W + 1);

  logic scl_s, scl_rise_c, scl_fall_c;
  logic sda_s, sda_rise_c, sda_fall_c;
  logic start_c, stop_c;

  state_t                state, state_n;
  logic [BIT_W-1:0]      bit_cnt, bit_cnt_n;
  logic [I2C_DATA_W-1:0] shift, shift_n;
  logic [I2C_DATA_W-1:0] rx_data_n;
  logic                  rw, rw_n;
  logic                  ack_hold, ack_hold_n;
  logic                  sda_oe, sda_oe_n;
  logic                  rx_valid_n, rd_req_n, busy_n;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (
    .clk(clk), .rst(rst), .line(i2c_scl),
    .sample(scl_s), .rise_c(scl_rise_c), .fall_c(scl_fall_c)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (
    .clk(clk), .rst(rst), .line(i2c_sda),
    .sample(sda_s), .rise_c(sda_rise_c), .fall_c(sda_fall_c)
  );

  assign start_c = scl_s & sda_fall_c;
  assign stop_c  = scl_s & sda_rise_c;

  // Open-drain: only ever pull low
  assign i2c_sda = sda_oe ? 1'b0 : 1'bz;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      shift    <= '0;
      rw       <= RW_WRITE;
      ack_hold <= 1'b0;
      sda_oe   <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rd_req   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
      rw       <= rw_n;
      ack_hold <= ack_hold_n;
      sda_oe   <= sda_oe_n;
      rx_data  <= rx_data_n;
      rx_valid <= rx_valid_n;
      rd_req   <= rd_req_n;
      busy     <= busy_n;
    end
  end

  // Next state and output values; START/STOP override bit handling
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    rw_n       = rw;
    ack_hold_n = ack_hold;
    sda_oe_n   = sda_oe;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    rd_req_n   = 1'b0;

    if (start_c) begin
      state_n    = ST_ADDR;
      bit_cnt_n  = '0;
      ack_hold_n = 1'b0;
      sda_oe_n   = 1'b0;
    end else if (stop_c) begin
      state_n  = ST_IDLE;
      sda_oe_n = 1'b0;
    end else begin
      case (state)
        ST_ADDR: begin
          if (scl_rise_c) begin
            shift_n   = {shift[I2C_DATA_W-2:0], sda_s};
            bit_cnt_n = bit_cnt + 1'b1;
            if (bit_cnt == BIT_W'(I2C_DATA_W - 1)) begin
              bit_cnt_n = '0;
              if (shift[I2C_ADDR_W-1:0] == TARGET_ADDR) begin
                state_n    = ST_ADDR_ACK;
                rw_n       = sda_s;
                ack_hold_n = 1'b0;
                rd_req_n   = (sda_s == RW_READ);
              end else begin
                state_n = ST_IGNORE;
              end
            end
          end
        end

        ST_ADDR_ACK: begin
          if (rd_req) begin
            shift_n = tx_data;
          end else if (scl_fall_c) begin
            if (!ack_hold) begin
              sda_oe_n   = 1'b1;
              ack_hold_n = 1'b1;
            end else begin
              ack_hold_n = 1'b0;
              if (rw == RW_READ) begin
                state_n   = ST_RD_DATA;
                sda_oe_n  = ~shift[I2C_DATA_W-1];
                shift_n   = {shift[I2C_DATA_W-2:0], 1'b0};
                bit_cnt_n = BIT_W'(1);
              end else begin
                state_n   = ST_WR_DATA;
                sda_oe_n  = 1'b0;
                bit_cnt_n = '0;
              end
            end
          end
        end

        ST_WR_DATA: begin
          if (scl_rise_c) begin
            shift_n   = {shift[I2C_DATA_W-2:0], sda_s};
            bit_cnt_n = bit_cnt + 1'b1;
            if (bit_cnt == BIT_W'(I2C_DATA_W - 1)) begin
              rx_data_n  = {shift[I2C_DATA_W-2:0], sda_s};
              rx_valid_n = 1'b1;
              bit_cnt_n  = '0;
              ack_hold_n = 1'b0;
              state_n    = ST_WR_ACK;
            end
          end
        end

        ST_WR_ACK: begin
          if (scl_fall_c) begin
            if (!ack_hold) begin
              sda_oe_n   = 1'b1;
              ack_hold_n = 1'b1;
            end else begin
              sda_oe_n   = 1'b0;
              ack_hold_n = 1'b0;
              state_n    = ST_IDLE;
            end
          end
        end

        ST_RD_DATA: begin
          if (scl_fall_c) begin
            if (bit_cnt == BIT_W'(I2C_DATA_W)) begin
              sda_oe_n  = 1'b0;
              bit_cnt_n = '0;
              state_n   = ST_RD_ACK;
            end else begin
              sda_oe_n  = ~shift[I2C_DATA_W-1];
              shift_n   = {shift[I2C_DATA_W-2:0], 1'b0};
              bit_cnt_n = bit_cnt + 1'b1;
            end
          end
        end

        // ACK or NACK both end the single-byte read
        ST_RD_ACK: begin
          if (scl_rise_c) state_n = ST_IDLE;
        end

        default: ;
      endcase
    end

    busy_n = (state_n != ST_IDLE);
  end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged controller on SCL/SDA, scoreboard
// queues for rx_valid/rd_req, and a monitor that performs all comparisons.
module tb_i2c_target;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       ctl_low;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid, rd_req, busy;
  wire        sda;

  pullup (sda);
  assign sda = ctl_low ? 1'b0 : 1'bz;

  i2c_target dut (
    .clk(clk), .rst(rst), .i2c_scl(scl), .i2c_sda(sda),
    .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid),
    .rd_req(rd_req), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] act;
    logic [7:0] exp;
  } req_t;

  req_t       req_q[$];
  logic [7:0] exp_rx[$];
  int         exp_rd[$];
  int         checks   = 0;
  int         failures = 0;

  // Monitor: pops expectations on DUT output pulses and drains direct checks
  always @(negedge clk) begin
    if (rx_valid) begin
      checks++;
      if (exp_rx.size() == 0) begin
        failures++;
        $display("FAIL rx_valid_unexpected actual=1 required=0 rx_data=%02h", rx_data);
      end else begin
        logic [7:0] e;
        e = exp_rx.pop_front();
        if (rx_data !== e) begin
          failures++;
          $display("FAIL rx_data_pulse actual=%02h required=%02h", rx_data, e);
        end
      end
    end
    if (rd_req) begin
      checks++;
      if (exp_rd.size() == 0) begin
        failures++;
        $display("FAIL rd_req_unexpected actual=1 required=0");
      end else begin
        void'(exp_rd.pop_front());
      end
    end
    while (req_q.size() > 0) begin
      req_t r;
      r = req_q.pop_front();
      checks++;
      if (r.act !== r.exp) begin
        failures++;
        $display("FAIL %s actual=%02h required=%02h", r.name, r.act, r.exp);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    req_t r;
    r.name = name;
    r.act  = act;
    r.exp  = exp;
    req_q.push_back(r);
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start();
    if (!scl) begin
      ctl_low = 1'b0; wclk(5);
      scl = 1'b1;     wclk(5);
    end
    ctl_low = 1'b1; wclk(10);
    scl = 1'b0;     wclk(5);
  endtask

  task automatic do_stop();
    ctl_low = 1'b1; wclk(5);
    scl = 1'b1;     wclk(10);
    ctl_low = 1'b0; wclk(10);
  endtask

  task automatic send_bit(input logic b);
    ctl_low = ~b; wclk(5);
    scl = 1'b1;   wclk(10);
    scl = 1'b0;   wclk(5);
  endtask

  task automatic read_bit(output logic b);
    ctl_low = 1'b0; wclk(5);
    scl = 1'b1;     wclk(5);
    b = sda;        wclk(5);
    scl = 1'b0;     wclk(5);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic read_byte(output logic [7:0] v);
    logic b;
    v = '0;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      v[i] = b;
    end
  endtask

  initial begin
    logic       a;
    logic [7:0] d;

    rst = 1'b1; scl = 1'b1; ctl_low = 1'b0; tx_data = 8'h00;
    wclk(4);
    rst = 1'b0;
    wclk(2);

    // Reset values
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_rx_valid", {7'd0, rx_valid}, 8'h00);
    chk("reset_rd_req", {7'd0, rd_req}, 8'h00);
    chk("reset_busy", {7'd0, busy}, 8'h00);
    chk("reset_sda_released", {7'd0, sda}, 8'h01);

    // Write 0x29 <- 0xA5
    exp_rx.push_back(8'hA5);
    do_start();
    chk("wr_busy_after_start", {7'd0, busy}, 8'h01);
    send_byte(8'h52);
    read_bit(a);
    chk("wr_addr_ack", {7'd0, a}, 8'h00);
    send_byte(8'hA5);
    read_bit(a);
    chk("wr_data_ack", {7'd0, a}, 8'h00);
    do_stop();
    chk("wr_rx_data", rx_data, 8'hA5);
    chk("wr_busy_after_stop", {7'd0, busy}, 8'h00);

    // Read 0x29 -> 0x3C, controller NACKs
    tx_data = 8'h3C;
    exp_rd.push_back(1);
    do_start();
    send_byte(8'h53);
    read_bit(a);
    chk("rd_addr_ack", {7'd0, a}, 8'h00);
    read_byte(d);
    chk("rd_data", d, 8'h3C);
    send_bit(1'b1);
    do_stop();
    chk("rd_busy_after_stop", {7'd0, busy}, 8'h00);
    chk("rd_rx_data_kept", rx_data, 8'hA5);

    // Address mismatch 0x2A: NACK, target stays off the bus
    do_start();
    send_byte(8'h54);
    read_bit(a);
    chk("nomatch_ack", {7'd0, a}, 8'h01);
    chk("nomatch_busy_ignore", {7'd0, busy}, 8'h01);
    do_stop();
    chk("nomatch_busy_after_stop", {7'd0, busy}, 8'h00);

    // Repeated START after a partial address, then write 0x5A
    do_start();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    exp_rx.push_back(8'h5A);
    do_start();
    send_byte(8'h52);
    read_bit(a);
    chk("rs_addr_ack", {7'd0, a}, 8'h00);
    send_byte(8'h5A);
    read_bit(a);
    chk("rs_data_ack", {7'd0, a}, 8'h00);
    do_stop();
    chk("rs_rx_data", rx_data, 8'h5A);

    // STOP after 4 data bits: byte discarded
    do_start();
    send_byte(8'h52);
    read_bit(a);
    chk("abort_addr_ack", {7'd0, a}, 8'h00);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    do_stop();
    chk("abort_busy", {7'd0, busy}, 8'h00);
    chk("abort_rx_data", rx_data, 8'h5A);

    // Reset while the target drives bit 7 (0) of 0x3C
    tx_data = 8'h3C;
    exp_rd.push_back(1);
    do_start();
    send_byte(8'h53);
    read_bit(a);
    chk("rstrd_addr_ack", {7'd0, a}, 8'h00);
    wclk(4);
    chk("rstrd_sda_driven_low", {7'd0, sda}, 8'h00);
    rst = 1'b1;
    wclk(1);
    rst = 1'b0;
    chk("rstrd_sda_released", {7'd0, sda}, 8'h01);
    chk("rstrd_busy", {7'd0, busy}, 8'h00);
    chk("rstrd_rx_data", rx_data, 8'h00);
    chk("rstrd_rd_req", {7'd0, rd_req}, 8'h00);
    chk("rstrd_rx_valid", {7'd0, rx_valid}, 8'h00);
    do_stop();
    chk("rstrd_busy_after_stop", {7'd0, busy}, 8'h00);

`ifdef I2C_TARGET_FILTER_EN
    // 2-cycle SDA low glitch while SCL high in IDLE must not look like START
    ctl_low = 1'b1; wclk(2);
    ctl_low = 1'b0; wclk(20);
    chk("glitch_busy", {7'd0, busy}, 8'h00);
`endif

    wclk(5);
    chk("rx_queue_drained", 8'(exp_rx.size()), 8'h00);
    chk("rd_queue_drained", 8'(exp_rd.size()), 8'h00);
    wclk(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
# i2c_target

Single-clock I2C target (slave) that sits directly downstream of `i2c_controller` on the shared SCL/SDA bus. It oversamples SCL/SDA with the system clock, detects START/STOP, matches a 7-bit address, and runs one-byte transfers:
- **Write:** it receives a byte and hands it to local logic.
- **Read:** it returns a byte supplied by local logic.

It is the bench and peripheral-side counterpart used to close the loop on the controller.

## Interface
- `TARGET_ADDR`, default `7'h29`: 7-bit address this target responds to.
- `FILTER_LEN`, default `3`: stable-sample count for the input filter; used only when `I2C_TARGET_FILTER_EN` is defined.
- `clk` in 1: system clock.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `i2c_scl` in 1: bus clock, observed only; the target never stretches SCL.
- `i2c_sda` inout 1: bus data. Driven open-drain: `1'b0` or `z`, never `1`.
- `tx_data` in 8: byte returned on a read; sampled at the cycle `rd_req` is high.
- `rx_data` out 8: last byte written by the controller.
- `rx_valid` out 1: one-cycle pulse; `rx_data` is updated that cycle.
- `rd_req` out 1: one-cycle pulse when a matched read address has been acknowledged.
- `busy` out 1: high from detected START until STOP or return to IDLE.

## Operation
- **Input path:** 2-flop synchronizer on SCL and SDA, then one registered sample stage. Rising, falling, START and STOP events are derived from the current and previous registered samples.
- **START:** SDA falls while SCL is high, in any state. The bit counter is cleared and the FSM goes to ADDR; this covers repeated START.
- **STOP:** SDA rises while SCL is high, in any state. The FSM goes to IDLE and SDA is released.
- **States:** IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
- **ADDR:**
  - Shift SDA on each SCL rise, MSB first, for 8 bits (address then R/W).
  - On the 8th rise, go to ADDR_ACK if the address equals `TARGET_ADDR`, else go to IGNORE.
- **ADDR_ACK:**
  - On the next SCL fall, drive SDA low.
  - On the following SCL fall, release SDA and go to WR_DATA (R/W=0) or RD_DATA (R/W=1).
  - For a read, `rd_req` pulses on entry to ADDR_ACK and `tx_data` is latched into the shift register.
- **WR_DATA:**
  - Shift 8 bits on SCL rises.
  - On the 8th rise, update `rx_data` and pulse `rx_valid`, then go to WR_ACK.
- **WR_ACK:** Drive SDA low from the next SCL fall to the one after, then return to IDLE. Write data is always acknowledged.
- **RD_DATA:**
  - Present bit 7 on SDA at the SCL fall that ends ADDR_ACK.
  - Present each following bit on each subsequent SCL fall.
  - A `1` bit means release; a `0` bit means drive low.
  - After 8 bits, release SDA at the next SCL fall and go to RD_ACK.
- **RD_ACK:** Sample the controller's ACK/NACK on the SCL rise, then go to IDLE. A single byte is sent per transaction in both cases.
- **IGNORE:** SDA is never driven; the FSM waits for START or STOP.
- **Reset:** the FSM goes to IDLE, SDA is released, the bit counter is 0, and the shift registers are 0.

## Timing
- **Reset values:**
  - `rx_data`=`8'h00`.
  - `rx_valid`=0, `rd_req`=0, `busy`=0.
  - SDA = `z`.
- **Input latency:** 3 `clk` cycles from a bus pin to its registered sample. An additional `FILTER_LEN` cycles apply when the filter is enabled.
- **Output latency:**
  - SDA drive changes 1 `clk` after the detected SCL fall.
  - `rx_valid` asserts 1 `clk` after the detected 8th data rise.
- **Clock requirement:** SCL high and low phases must each be at least 6 `clk` cycles, or `6+FILTER_LEN` with the filter enabled.
- **Simultaneous events:** START/STOP take priority over bit-shift handling in the same cycle.
- **Reset mid-transfer:** SDA is released in the cycle after `rst` is sampled high, and no `rx_valid` is produced.
- **STOP or START mid-byte:** the partial byte is discarded; no `rx_valid` and no `rd_req`.

## Configuration
- **`I2C_TARGET_FILTER_EN` defined:**
  - A per-line deglitch filter is inserted after the synchronizer.
  - The filtered value changes only after `FILTER_LEN` consecutive equal samples.
  - Pulses shorter than `FILTER_LEN` cycles are ignored.
- **Not defined:** the filter is absent and the synchronizer output feeds edge detection directly.

## Structure
- **Shared package `i2c_pkg`:**
  - FSM state enum.
  - `I2C_ADDR_W`=7, `I2C_DATA_W`=8.
  - R/W bit encoding: 0 = write, 1 = read.
  - Also consumed by the controller's bench.
- **Sub-module `i2c_line_filter`:** one instance per line. It holds the synchronizer, the filter under the macro, and the registered sample plus rise/fall outputs.

## Test plan
- **Write:** controller writes addr `0x29`, data `0xA5` → ACK low on the 9th SCL; a single `rx_valid` pulse with `rx_data`=`0xA5`; data ACK on the 18th SCL.
- **Read:** controller reads addr `0x29`, `tx_data`=`0x3C` → one `rd_req` pulse; SDA bits 0,0,1,1,1,1,0,0; controller `data_out`=`0x3C`; IDLE after STOP.
- **Address mismatch:** controller addresses `0x2A` → SDA never driven low by the target; controller sees NACK and issues STOP; no `rx_valid`.
- **Aborted byte:** STOP injected after 4 data bits of a write → FSM in IDLE; `busy`=0; no `rx_valid`; `rx_data` unchanged.
- **Reset mid-read:** `rst` pulsed for 1 cycle during RD_DATA while driving a 0 bit → SDA = `z` on the next cycle; all outputs at reset values.
- **Glitch (with `I2C_TARGET_FILTER_EN`, `FILTER_LEN`=3):** 2-cycle SDA low pulse while SCL is high in IDLE → no START; `busy` stays 0.
